// File: rtl/i2s_capture.sv
// I2S receive deserializer: oversamples BCLK/LRCLK/SDATA and pushes {ch, seq, sample} words.
// Build macro I2S_CAPTURE_LEFT_ONLY_EN: skip right half-frames and push left words only.
module i2s_capture #(
   parameter int unsigned SAMPLE_BITS = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        i2s_bclk,
   input  logic        i2s_lrclk,
   input  logic        i2s_sdata,
   output logic [31:0] wr_data,
   output logic        wr_en,
   input  logic        wr_full,
   output logic        overflow,
   output logic [15:0] drop_count,
   output logic [7:0]  frame_err_count
);

   localparam int unsigned PadBits = 24 - SAMPLE_BITS;
   localparam logic [4:0]  LastBit = 5'(SAMPLE_BITS - 1);

   typedef enum logic [2:0] {StIdle, StSkip, StShift, StPush, StWait} state_e;

   // Each synchronizer stage carries {sdata, lrclk, bclk}.
   logic [2:0]  sync_q [SYNC_STAGES];
   logic [2:0]  sync_d [SYNC_STAGES];
   logic        bclk_prev_q, bclk_prev_d;
   logic        lr_prev_q, lr_prev_d;
   logic        bclk_s, lr_s, sd_s;
   logic        bclk_rise, lr_edge;

   state_e      state_q, state_d, rs_state;
   logic        ch_q, ch_d;
   logic [6:0]  seq_q, seq_d, rs_seq;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] shreg_q, shreg_d;
   logic [23:0] sample_lj;
   logic [31:0] hold_q, hold_d;
   logic [31:0] word;
   logic        pend_q, pend_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_q, drop_d;
   logic [7:0]  err_q, err_d;

   always_comb begin
      sync_d[0] = {i2s_sdata, i2s_lrclk, i2s_bclk};
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign bclk_s      = sync_q[SYNC_STAGES-1][0];
   assign lr_s        = sync_q[SYNC_STAGES-1][1];
   assign sd_s        = sync_q[SYNC_STAGES-1][2];
   assign bclk_prev_d = bclk_s;
   assign lr_prev_d   = lr_s;
   assign bclk_rise   = bclk_s & ~bclk_prev_q;
   assign lr_edge     = lr_s ^ lr_prev_q;

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      seq_d      = seq_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      hold_d     = hold_q;
      pend_d     = 1'b0;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_data    = hold_q;
      sample_lj  = shreg_q << PadBits;
      word       = {ch_q, seq_q, sample_lj};

      // Target of a half-frame boundary: a new left half-frame bumps the frame counter.
      rs_state = StSkip;
`ifdef I2S_CAPTURE_LEFT_ONLY_EN
      if (lr_s) rs_state = StWait;
`endif
      rs_seq = lr_s ? seq_q : seq_q + 7'd1;

      unique case (state_q)
         StIdle: begin
            if (en && lr_edge && !lr_s) begin
               state_d = StSkip;
               ch_d    = 1'b0;
               seq_d   = 7'd0;
            end
         end
         StSkip: begin
            if (lr_edge) begin
               state_d = rs_state;
               ch_d    = lr_s;
               seq_d   = rs_seq;
            end else if (bclk_rise) begin
               state_d = StShift;
               cnt_d   = 5'd0;
            end
         end
         StShift: begin
            if (lr_edge) begin
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = rs_state;
               ch_d    = lr_s;
               seq_d   = rs_seq;
            end else if (bclk_rise) begin
               shreg_d = {shreg_q[22:0], sd_s};
               cnt_d   = cnt_q + 5'd1;
               if (cnt_q == LastBit) state_d = StPush;
            end
         end
         StPush: begin
            wr_data = word;
            if (!wr_full) begin
               wr_en  = 1'b1;
               hold_d = word;
            end else begin
               overflow_d = 1'b1;
               if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
            // An LRCLK edge landing in this cycle is serviced from WAIT next cycle.
            pend_d  = lr_edge;
            state_d = StWait;
         end
         StWait: begin
            if (lr_edge || pend_q) begin
               state_d = rs_state;
               ch_d    = lr_s;
               seq_d   = rs_seq;
            end
         end
         default: state_d = StIdle;
      endcase

      if (!en) state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 3'b000;
         bclk_prev_q <= 1'b0;
         lr_prev_q   <= 1'b0;
         state_q     <= StIdle;
         ch_q        <= 1'b0;
         seq_q       <= 7'd0;
         cnt_q       <= 5'd0;
         shreg_q     <= 24'd0;
         hold_q      <= 32'd0;
         pend_q      <= 1'b0;
         overflow_q  <= 1'b0;
         drop_q      <= 16'd0;
         err_q       <= 8'd0;
      end else begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
         bclk_prev_q <= bclk_prev_d;
         lr_prev_q   <= lr_prev_d;
         state_q     <= state_d;
         ch_q        <= ch_d;
         seq_q       <= seq_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         overflow_q  <= overflow_d;
         drop_q      <= drop_d;
         err_q       <= err_d;
      end
   end

   assign overflow        = overflow_q;
   assign drop_count      = drop_q;
   assign frame_err_count = err_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Self-checking bench for i2s_capture: directed table of frames plus a randomized stream
// scored against a frame-level reference model.
module tb_i2s_capture;

`ifdef I2S_CAPTURE_LEFT_ONLY_EN
   localparam bit LeftOnly = 1'b1;
`else
   localparam bit LeftOnly = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, i2s_bclk, i2s_lrclk, i2s_sdata, wr_full;
   logic [31:0] wr_data;
   logic        wr_en, overflow;
   logic [15:0] drop_count;
   logic [7:0]  frame_err_count;

   i2s_capture dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .i2s_bclk        (i2s_bclk),
      .i2s_lrclk       (i2s_lrclk),
      .i2s_sdata       (i2s_sdata),
      .wr_data         (wr_data),
      .wr_en           (wr_en),
      .wr_full         (wr_full),
      .overflow        (overflow),
      .drop_count      (drop_count),
      .frame_err_count (frame_err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [31:0] exp_l;
      logic [31:0] exp_r;
   } vec_t;

   vec_t        vecs [4];
   logic [31:0] got_q [$];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          exp_drops = 0;
   int          exp_errs = 0;
   int          bclk_half = 8;
   logic        wen_prev = 1'b0;
   logic        b2b = 1'b0;

   always @(negedge clk) begin
      if (wr_en) got_q.push_back(wr_data);
      if (wr_en && wen_prev) b2b <= 1'b1;
      wen_prev <= wr_en;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void expect_word(input logic [31:0] w);
      if (!(LeftOnly && w[31])) exp_q.push_back(w);
   endfunction

   function automatic void expect_drop(input logic ch);
      if (!(LeftOnly && ch)) exp_drops++;
   endfunction

   task automatic compare_words(input string name);
      check({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check({name, "_word"}, got_q[i], exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_counters(input string name);
      check({name, "_drop_count"}, {16'd0, drop_count}, exp_drops);
      check({name, "_frame_err"}, {24'd0, frame_err_count}, exp_errs);
      check({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_drops != 0});
   endtask

   // One half-frame of len BCLK slots: slot 0 is the I2S delay bit, slots 1..24 the sample.
   task automatic send_half(input logic lr, input logic [23:0] val, input int len,
                            input logic full, input int en_off, input int rst_at);
      wr_full = full;
      for (int s = 0; s < len; s++) begin
         i2s_bclk  = 1'b0;
         i2s_lrclk = lr;
         if (s >= 1 && s <= 24) i2s_sdata = val[24-s];
         else i2s_sdata = 1'($urandom_range(0, 1));
         if (s == en_off) en = 1'b0;
         if (s == rst_at) begin
            rst = 1'b1;
            wait_clk(1);
            rst = 1'b0;
            check("rst_wr_en", {31'd0, wr_en}, 32'd0);
            check("rst_wr_data", wr_data, 32'd0);
            check("rst_overflow", {31'd0, overflow}, 32'd0);
            check("rst_drop_count", {16'd0, drop_count}, 32'd0);
            check("rst_frame_err", {24'd0, frame_err_count}, 32'd0);
            wait_clk(bclk_half - 1);
         end else begin
            wait_clk(bclk_half);
         end
         i2s_bclk = 1'b1;
         wait_clk(bclk_half);
      end
      wr_full = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_half(1'b0, l, 32, 1'b0, -1, -1);
      send_half(1'b1, r, 32, 1'b0, -1, -1);
   endtask

   initial begin
      logic        first;
      int          frame;
      logic        lr;
      logic [23:0] val;
      int          len;
      logic        full;

      vecs[0] = '{24'h123456, 24'hABCDEF, 32'h00123456, 32'h80ABCDEF};
      vecs[1] = '{24'h123456, 24'hABCDEF, 32'h01123456, 32'h81ABCDEF};
      vecs[2] = '{24'h000000, 24'hFFFFFF, 32'h02000000, 32'h82FFFFFF};
      vecs[3] = '{24'h800001, 24'h7FFFFE, 32'h03800001, 32'h837FFFFE};

      rst = 1'b1; en = 1'b0; wr_full = 1'b0;
      i2s_bclk = 1'b0; i2s_lrclk = 1'b1; i2s_sdata = 1'b0;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(1);
      check("reset_wr_en", {31'd0, wr_en}, 32'd0);
      check("reset_wr_data", wr_data, 32'd0);
      check_counters("reset");

      // Basic capture from the vector table.
      en = 1'b1;
      wait_clk(4);
      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].l, vecs[i].r);
         expect_word(vecs[i].exp_l);
         expect_word(vecs[i].exp_r);
      end
      wait_clk(8);
      compare_words("basic");
      check_counters("basic");

      // Enable rises during a right half-frame: first word must be a left one with seq 0.
      en = 1'b0;
      send_half(1'b0, 24'h777777, 32, 1'b0, -1, -1);
      en = 1'b1;
      send_half(1'b1, 24'h666666, 32, 1'b0, -1, -1);
      send_frame(24'h111111, 24'h222222);
      expect_word(32'h00111111);
      expect_word(32'h80222222);
      wait_clk(8);
      compare_words("midstart");

      // Overflow over three slots, then frame numbering must have kept counting.
      send_half(1'b0, 24'h0000AA, 32, 1'b1, -1, -1); expect_drop(1'b0);
      send_half(1'b1, 24'h0000BB, 32, 1'b1, -1, -1); expect_drop(1'b1);
      send_half(1'b0, 24'h0000CC, 32, 1'b1, -1, -1); expect_drop(1'b0);
      send_half(1'b1, 24'h0000DD, 32, 1'b0, -1, -1); expect_word(32'h820000DD);
      send_frame(24'h0000EE, 24'h0000FF);
      expect_word(32'h030000EE);
      expect_word(32'h830000FF);
      wait_clk(8);
      compare_words("overflow");
      check_counters("overflow");

      // Short left half-frame: LRCLK toggles after 10 sample bits.
      send_half(1'b0, 24'h999999, 11, 1'b0, -1, -1);
      exp_errs++;
      send_half(1'b1, 24'h5A5A5A, 32, 1'b0, -1, -1); expect_word(32'h845A5A5A);
      send_frame(24'h0F0F0F, 24'hF0F0F0);
      expect_word(32'h050F0F0F);
      expect_word(32'h85F0F0F0);
      wait_clk(8);
      compare_words("short");
      check_counters("short");

      // Disable mid-sample, then reset mid-frame; capture restarts at seq 0.
      send_half(1'b0, 24'h313131, 32, 1'b0, 10, -1);
      send_half(1'b1, 24'h424242, 32, 1'b0, -1, -1);
      en = 1'b1;
      send_half(1'b0, 24'h535353, 32, 1'b0, -1, 12);
      exp_drops = 0;
      exp_errs = 0;
      send_half(1'b1, 24'h646464, 32, 1'b0, -1, -1);
      send_frame(24'hC0FFEE, 24'hBEEF01);
      expect_word(32'h00C0FFEE);
      expect_word(32'h80BEEF01);
      wait_clk(8);
      compare_words("disable_reset");
      check_counters("disable_reset");

      // Randomized stream at BCLK = clk/4, long enough for seq to wrap.
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      exp_drops = 0;
      exp_errs = 0;
      got_q.delete();
      exp_q.delete();
      bclk_half = 2;
      wait_clk(4);
      first = 1'b1;
      frame = 0;
      for (int hf = 0; hf < 264; hf++) begin
         lr   = 1'(hf % 2);
         val  = 24'($urandom);
         len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 24)) : 32;
         full = ($urandom_range(0, 7) == 0);
         if (!lr) begin
            if (first) first = 1'b0;
            else frame++;
         end
         if (!(LeftOnly && lr)) begin
            if (len >= 25) begin
               if (full) exp_drops++;
               else exp_q.push_back({lr, 7'(frame % 128), val});
            end else begin
               exp_errs++;
            end
         end
         send_half(lr, val, len, full, -1, -1);
      end
      wait_clk(8);
      compare_words("random");
      check_counters("random");

      check("no_b2b_wr_en", {31'd0, b2b}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
